// File: rtl/retire_unit.sv
// Retire/writeback stage: commits ALU/CSR results and aligned load data to the register file.
// Optional INSTRET_COUNTER_EN adds a 64-bit retired-instruction counter; otherwise instret_o is 0.
// Opcodes (4 bits): NOP=0 ADD=1 LB=2 LBU=3 LH=4 LHU=5 LW=6 SB=7 SH=8 SW=9 BEQ=10 BNE=11 CSR=12.
module retire_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  instruction_operation_i,
  input  logic        write_enable_i,
  input  logic [31:0] result_i,
  input  logic [4:0]  rd_i,
  input  logic [1:0]  load_offset_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  output logic        regbank_we_o,
  output logic [4:0]  regbank_addr_o,
  output logic [31:0] regbank_data_o,
  output logic        mem_stall_o,
  output logic [63:0] instret_o
);

  localparam logic [3:0] OP_LB  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_LH  = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_LW  = 4'd6;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_is_load;
  logic        w_stall;
  logic        w_commit;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_wdata;

  assign w_is_load = write_enable_i &&
                     (instruction_operation_i == OP_LB  || instruction_operation_i == OP_LBU ||
                      instruction_operation_i == OP_LH  || instruction_operation_i == OP_LHU ||
                      instruction_operation_i == OP_LW);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Stall is held low under reset so upstream is never frozen by a dying load.
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_is_load && !mem_valid_i) begin
            w_stall      = 1'b1;
            w_state_next = WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (mem_valid_i) w_state_next = IDLE;
          else             w_stall      = 1'b1;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign mem_stall_o = w_stall;
  assign w_commit    = !reset && !w_stall;

  assign w_byte = mem_data_i[8*load_offset_i +: 8];
  assign w_half = load_offset_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];

  always_comb begin
    w_wdata = result_i;
    case (instruction_operation_i)
      OP_LB:   w_wdata = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_wdata = {24'd0, w_byte};
      OP_LH:   w_wdata = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_wdata = {16'd0, w_half};
      OP_LW:   w_wdata = mem_data_i;
      default: w_wdata = result_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regbank_we_o   <= 1'b0;
      regbank_addr_o <= 5'd0;
      regbank_data_o <= 32'd0;
    end else begin
      regbank_we_o <= w_commit && write_enable_i && (rd_i != 5'd0);
      if (w_commit) begin
        regbank_addr_o <= rd_i;
        regbank_data_o <= w_wdata;
      end
    end
  end

`ifdef INSTRET_COUNTER_EN
  localparam logic [3:0] OP_SB  = 4'd7;
  localparam logic [3:0] OP_SH  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;
  localparam logic [3:0] OP_BNE = 4'd11;

  logic        w_store_branch;
  logic        w_retire;
  logic [63:0] r_instret;

  assign w_store_branch = (instruction_operation_i == OP_SB  || instruction_operation_i == OP_SH ||
                           instruction_operation_i == OP_SW  || instruction_operation_i == OP_BEQ ||
                           instruction_operation_i == OP_BNE);
  assign w_retire = w_commit && (write_enable_i || w_store_branch);

  always_ff @(posedge clk) begin
    if (reset)         r_instret <= 64'd0;
    else if (w_retire) r_instret <= r_instret + 64'd1;
  end

  assign instret_o = r_instret;
`else
  assign instret_o = 64'd0;
`endif

endmodule

// File: doc/retire_unit.md
RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: instruction_operation_i  in  iType_e  operation registered by execute stage.
REQ-004 SHALL have port: write_enable_i  in  1  execute-stage write enable; already low for killed, store and branch.
REQ-005 SHALL have port: result_i  in  32  execute-stage result (ALU, CSR read, link address).
REQ-006 SHALL have port: rd_i  in  5  destination register index.
REQ-007 SHALL have port: load_offset_i  in  2  byte offset of load address, registered alongside result_i.
REQ-008 SHALL have port: mem_valid_i  in  1  data memory read data valid.
REQ-009 SHALL have port: mem_data_i  in  32  data memory read word.
REQ-010 SHALL have port: regbank_we_o  out  1  register file write strobe.
REQ-011 SHALL have port: regbank_addr_o  out  5  register file write index.
REQ-012 SHALL have port: regbank_data_o  out  32  register file write data.
REQ-013 SHALL have port: mem_stall_o  out  1  pipeline hold while a load waits for memory.
REQ-014 SHALL have port: instret_o  out  64  retired-instruction count.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_MEM; reset state IDLE.
REQ-016 Load = operation in {LB, LBU, LH, LHU, LW} with write_enable_i high; IDLE + load + !mem_valid_i SHALL go to WAIT_MEM.
REQ-017 WAIT_MEM + mem_valid_i SHALL commit load and return to IDLE; otherwise remain.
REQ-018 mem_stall_o SHALL be combinational: high in IDLE on load with !mem_valid_i, high in WAIT_MEM while !mem_valid_i, else low.
REQ-019 Upstream SHALL hold all *_i inputs stable while mem_stall_o is high; unit SHALL NOT sample new operations during stall.
REQ-020 Commit SHALL register regbank_we_o/addr/data one cycle after commit condition (latency 1).
REQ-021 Non-load commit: every cycle mem_stall_o low; data = result_i; we = write_enable_i.
REQ-022 LB/LBU: byte mem_data_i[8*offset+7 : 8*offset], sign-/zero-extended to 32.
REQ-023 LH/LHU: halfword selected by load_offset_i[1] only (offset[0] ignored), sign-/zero-extended.
REQ-024 LW: full mem_data_i; load_offset_i ignored.
REQ-025 rd_i == 0 SHALL force regbank_we_o low; instret still counts.
REQ-026 regbank_we_o SHALL be low in every cycle without a commit, including stall cycles.
REQ-027 Retirement = commit with write_enable_i high, or store/branch operation (we low, not killed per upstream contract: operation not NOP); counter SHALL increment by 1 per retirement, wrapping 2^64-1 -> 0.

Reset
REQ-028 reset SHALL force FSM IDLE, regbank_we_o 0, regbank_addr_o 0, regbank_data_o 0, instret_o 0 on next edge, overriding any pending load.
REQ-029 mem_stall_o SHALL be low during and after reset until a new load arrives.

Configuration
REQ-030 Macro INSTRET_COUNTER_EN defined: 64-bit counter per REQ-027.
REQ-031 Macro undefined: no counter flops; instret_o tied to 0; all other behaviour identical.

Verification
REQ-032 ADD, write_enable_i=1, rd=5, result=0x1234 -> next cycle we=1, addr=5, data=0x1234; instret +1.
REQ-033 LB, offset=3, mem_valid=1, mem_data=0x80FF_0000 -> data=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-034 LH offset=2, mem_valid low 3 cycles then high, data=0x8001_xxxx -> mem_stall_o high 3 cycles, single we pulse data=0xFFFF_8001.
REQ-035 reset asserted in WAIT_MEM -> next cycle FSM IDLE, stall low, we=0, instret=0; no late write on later mem_valid.
REQ-036 write_enable_i=1, rd=0 -> we stays 0; instret increments (counter build); instret preset 0xFFFF_FFFF_FFFF_FFFF + retire -> 0.
